// File: rtl/ttt_board_controller.sv
// rtl/ttt_board_controller.sv - 3x3 tic-tac-toe board, cursor, vblank-synchronous commit and win scan
// Define CURSOR_WRAP_EN to wrap the cursor at board edges; otherwise edge moves saturate.
module ttt_board_controller #(
  parameter logic [3:0] CURSOR_HOME  = 4'd4,
  parameter logic       FIRST_PLAYER = 1'b0
) (
  input  logic       clk_25Mhz,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_place,
  input  logic       new_game,
  input  logic       frame_start,
  input  logic [3:0] rd_cell,
  output logic [1:0] rd_mark,
  output logic [3:0] cursor,
  output logic       turn,
  output logic [1:0] status,
  output logic [2:0] win_line,
  output logic       busy,
  output logic       illegal
);
  localparam logic [1:0] S_PLAY    = 2'd0;
  localparam logic [1:0] S_PENDING = 2'd1;
  localparam logic [1:0] S_CHECK   = 2'd2;
  localparam logic [1:0] S_OVER    = 2'd3;

`ifdef CURSOR_WRAP_EN
  localparam logic WRAP = 1'b1;
`else
  localparam logic WRAP = 1'b0;
`endif

  logic [1:0] r_state;
  logic [1:0] r_board [0:8];
  logic [3:0] r_cursor;
  logic [3:0] r_pend_idx;
  logic [3:0] r_move_cnt;
  logic [2:0] r_line_idx;
  logic [2:0] r_win_line;
  logic [1:0] r_status;
  logic       r_turn;
  logic       r_illegal;

  logic [1:0] w_row;
  logic [1:0] w_col;
  logic [3:0] w_next_cursor;
  logic [3:0] w_a;
  logic [3:0] w_b;
  logic [3:0] w_c;
  logic [1:0] w_mark;
  logic       w_line_hit;
  logic       w_cell_taken;

  always_comb begin
    w_row = 2'd0;
    if (r_cursor >= 4'd6)      w_row = 2'd2;
    else if (r_cursor >= 4'd3) w_row = 2'd1;
  end

  assign w_col = 2'(r_cursor - {1'b0, w_row, 1'b0} - {2'b00, w_row});

  // Only one direction applies per cycle: up > down > left > right.
  always_comb begin
    w_next_cursor = r_cursor;
    if (btn_up) begin
      if (w_row != 2'd0)  w_next_cursor = r_cursor - 4'd3;
      else if (WRAP)      w_next_cursor = r_cursor + 4'd6;
    end else if (btn_down) begin
      if (w_row != 2'd2)  w_next_cursor = r_cursor + 4'd3;
      else if (WRAP)      w_next_cursor = r_cursor - 4'd6;
    end else if (btn_left) begin
      if (w_col != 2'd0)  w_next_cursor = r_cursor - 4'd1;
      else if (WRAP)      w_next_cursor = r_cursor + 4'd2;
    end else if (btn_right) begin
      if (w_col != 2'd2)  w_next_cursor = r_cursor + 4'd1;
      else if (WRAP)      w_next_cursor = r_cursor - 4'd2;
    end
  end

  always_comb begin
    case (r_line_idx)
      3'd0:    {w_a, w_b, w_c} = {4'd0, 4'd1, 4'd2};
      3'd1:    {w_a, w_b, w_c} = {4'd3, 4'd4, 4'd5};
      3'd2:    {w_a, w_b, w_c} = {4'd6, 4'd7, 4'd8};
      3'd3:    {w_a, w_b, w_c} = {4'd0, 4'd3, 4'd6};
      3'd4:    {w_a, w_b, w_c} = {4'd1, 4'd4, 4'd7};
      3'd5:    {w_a, w_b, w_c} = {4'd2, 4'd5, 4'd8};
      3'd6:    {w_a, w_b, w_c} = {4'd0, 4'd4, 4'd8};
      default: {w_a, w_b, w_c} = {4'd2, 4'd4, 4'd6};
    endcase
  end

  assign w_mark       = r_turn ? 2'b10 : 2'b01;
  assign w_line_hit   = (r_board[w_a] == w_mark) && (r_board[w_b] == w_mark) && (r_board[w_c] == w_mark);
  assign w_cell_taken = (r_board[r_cursor] != 2'b00);

  always_ff @(posedge clk_25Mhz or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) r_board[i] <= 2'b00;
      r_state    <= S_PLAY;
      r_cursor   <= CURSOR_HOME;
      r_pend_idx <= 4'd0;
      r_move_cnt <= 4'd0;
      r_line_idx <= 3'd0;
      r_win_line <= 3'd0;
      r_status   <= 2'b00;
      r_turn     <= FIRST_PLAYER;
      r_illegal  <= 1'b0;
    end else begin
      r_illegal <= 1'b0;
      if (new_game) begin
        for (int i = 0; i < 9; i++) r_board[i] <= 2'b00;
        r_state    <= S_PLAY;
        r_cursor   <= CURSOR_HOME;
        r_move_cnt <= 4'd0;
        r_line_idx <= 3'd0;
        r_win_line <= 3'd0;
        r_status   <= 2'b00;
        r_turn     <= FIRST_PLAYER;
      end else begin
        case (r_state)
          S_PLAY: begin
            if (btn_place) begin
              if (w_cell_taken) begin
                r_illegal <= 1'b1;
              end else begin
                r_pend_idx <= r_cursor;
                r_state    <= S_PENDING;
              end
            end else begin
              r_cursor <= w_next_cursor;
            end
          end
          S_PENDING: begin
            // Board only changes in vertical blank so the renderer never sees a half-updated frame.
            if (frame_start) begin
              r_board[r_pend_idx] <= w_mark;
              if (r_move_cnt != 4'd9) r_move_cnt <= r_move_cnt + 4'd1;
              r_line_idx <= 3'd0;
              r_state    <= S_CHECK;
            end
          end
          S_CHECK: begin
            if (w_line_hit) begin
              r_status   <= r_turn ? 2'b10 : 2'b01;
              r_win_line <= r_line_idx;
              r_state    <= S_OVER;
            end else if (r_line_idx == 3'd7) begin
              if (r_move_cnt == 4'd9) begin
                r_status <= 2'b11;
                r_state  <= S_OVER;
              end else begin
                r_turn  <= ~r_turn;
                r_state <= S_PLAY;
              end
            end else begin
              r_line_idx <= r_line_idx + 3'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign rd_mark  = (rd_cell <= 4'd8) ? r_board[rd_cell] : 2'b00;
  assign cursor   = r_cursor;
  assign turn     = r_turn;
  assign status   = r_status;
  assign win_line = r_win_line;
  assign busy     = (r_state == S_PENDING) || (r_state == S_CHECK);
  assign illegal  = r_illegal;

endmodule
